// File: rtl/clockworks_pkg.sv
// Shared constants and helpers for the clockworks_multi clock/reset front end.
//   DIV_W_DEF       default divider register width
//   DEFAULT_DIV_DEF default divider value loaded into every channel at reset
//   SYNC_STAGES     number of flops in the reset-release synchroniser
//   clog2_min1()    ceil(log2(n)) clamped to a minimum of 1 bit
package clockworks_pkg;

  localparam int DIV_W_DEF = 24;
  localparam logic [DIV_W_DEF-1:0] DEFAULT_DIV_DEF = 24'd11;
  localparam int SYNC_STAGES = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clockworks_div_ch.sv
// One programmable divider channel.
// Ports:
//   CLK, RESET   board clock, async active-high reset
//   run          channel counts only while the design reset is released
//   load         write strobe already decoded for this channel
//   load_value   new divider D (period D+1 cycles)
//   clk_en       one-cycle pulse per period (held high for D=0)
//   clk_slow     square wave toggling on every pulse
//   div_act      divider currently in force
module clockworks_div_ch #(
  parameter int               DIV_W       = 24,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 24'd11
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] load_value,
  output logic             clk_en,
  output logic             clk_slow,
  output logic [DIV_W-1:0] div_act
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_shadow;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      clk_en     <= 1'b0;
      clk_slow   <= 1'b0;
      div_act    <= DEFAULT_DIV;
      div_shadow <= DEFAULT_DIV;
    end else begin
      if (load) div_shadow <= load_value;
      if (!run) begin
        // Nothing is running yet, so a load can take effect at once.
        if (load) div_act <= load_value;
      end else if (cnt == div_act) begin
        cnt      <= '0;
        clk_en   <= 1'b1;
        clk_slow <= ~clk_slow;
        // A load landing on the wrap edge bypasses the shadow so the
        // very next period already uses it.
        div_act  <= load ? load_value : div_shadow;
      end else begin
        cnt    <= cnt + DIV_W'(1);
        clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clockworks_multi.sv
// Board clock/reset front end: NUM_CH programmable clock enables with
// matching divided square waves, plus a synchronised, stretched reset.
// Ports:
//   CLK        board clock (only clock)
//   RESET      board reset, async assert, active-high
//   div_load   divider write strobe
//   div_ch     channel index for div_load (out-of-range index is ignored)
//   div_value  new divider D
//   clk_en     per-channel enable pulse
//   clk_slow   per-channel square wave, period 2*(D+1)
//   reset_out  design reset, active-high, synchronously released
//   div_cur    active divider per channel, channel i at [i*DIV_W +: DIV_W]
module clockworks_multi
  import clockworks_pkg::*;
#(
  parameter int               NUM_CH      = 2,
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_DEF),
  parameter int               RST_CYCLES  = 16,
  parameter int               CH_W        = clog2_min1(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    div_load,
  input  logic [CH_W-1:0]         div_ch,
  input  logic [DIV_W-1:0]        div_value,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       clk_slow,
  output logic                    reset_out,
  output logic [NUM_CH*DIV_W-1:0] div_cur
);

  localparam logic [15:0] RST_MAX = 16'(RST_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic [15:0]            rst_cnt;
  logic [NUM_CH-1:0]      ch_load;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], 1'b0};
  end

  // Stretch counter saturates at RST_MAX; reset_out drops on the edge it
  // gets there and stays low until the next RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rst_cnt   <= '0;
      reset_out <= 1'b1;
    end else if (!sync_out && rst_cnt != RST_MAX) begin
      rst_cnt <= rst_cnt + 16'd1;
      if (rst_cnt == RST_MAX - 16'd1) reset_out <= 1'b0;
    end
  end

  always_comb begin
    ch_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_load[i] = div_load && (32'(div_ch) < NUM_CH) && (32'(div_ch) == i);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clockworks_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .CLK        (CLK),
      .RESET      (RESET),
      .run        (~reset_out),
      .load       (ch_load[i]),
      .load_value (div_value),
      .clk_en     (clk_en[i]),
      .clk_slow   (clk_slow[i]),
      .div_act    (div_cur[i*DIV_W +: DIV_W])
    );
  end

endmodule

// File: tb/tb_clockworks_multi.sv
module tb_clockworks_multi;

  localparam int NCH  = 3;
  localparam int DW   = 8;
  localparam int RSTC = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          div_load = 1'b0;
  logic [1:0]    div_ch = '0;
  logic [DW-1:0] div_value = '0;
  logic [NCH-1:0]    clk_en;
  logic [NCH-1:0]    clk_slow;
  logic              reset_out;
  logic [NCH*DW-1:0] div_cur;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  clockworks_multi #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .DEFAULT_DIV (8'd11),
    .RST_CYCLES  (RSTC)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .div_load  (div_load),
    .div_ch    (div_ch),
    .div_value (div_value),
    .clk_en    (clk_en),
    .clk_slow  (clk_slow),
    .reset_out (reset_out),
    .div_cur   (div_cur)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel keeps the absolute edge number of its
  // next wrap; a wrap reschedules itself D+1 edges later.
  int        m_k;
  int        m_low;
  bit        m_ro;
  bit        m_started;
  logic [DW-1:0] m_dact [NCH];
  logic [DW-1:0] m_dsh  [NCH];
  int        m_next [NCH];
  bit        m_en   [NCH];
  bit        m_slow [NCH];

  task automatic m_clear();
    m_low = 0;
    m_ro = 1'b1;
    m_started = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_dact[i] = 8'd11;
      m_dsh[i]  = 8'd11;
      m_next[i] = 0;
      m_en[i]   = 1'b0;
      m_slow[i] = 1'b0;
    end
  endtask

  initial begin
    bit prev_ro, ld, wrap;
    int lc;
    logic [DW-1:0] lv;
    m_k = 0;
    m_clear();
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        m_clear();
      end else begin
        m_k++;
        ld = div_load && (int'(div_ch) < NCH);
        lc = int'(div_ch);
        lv = div_value;
        prev_ro = m_ro;
        m_low++;
        m_ro = (m_low < RSTC + 2);
        if (!prev_ro && !m_started) begin
          m_started = 1'b1;
          for (int i = 0; i < NCH; i++) m_next[i] = m_k + int'(m_dact[i]);
        end
        for (int i = 0; i < NCH; i++) begin
          wrap = !prev_ro && (m_k == m_next[i]);
          m_en[i] = wrap;
          if (wrap) m_slow[i] = ~m_slow[i];
          if (ld && lc == i) begin
            m_dsh[i] = lv;
            if (prev_ro || wrap) m_dact[i] = lv;
          end else if (wrap) begin
            m_dact[i] = m_dsh[i];
          end
          if (wrap) m_next[i] = m_k + int'(m_dact[i]) + 1;
        end
      end
    end
  end

  initial forever begin
    logic [NCH-1:0] e_en, e_slow;
    logic [NCH*DW-1:0] e_div;
    @(negedge CLK);
    for (int i = 0; i < NCH; i++) begin
      e_en[i] = m_en[i];
      e_slow[i] = m_slow[i];
      e_div[i*DW +: DW] = m_dact[i];
    end
    chk("model_reset_out", 32'(reset_out), 32'(m_ro));
    chk("model_clk_en", 32'(clk_en), 32'(e_en));
    chk("model_clk_slow", 32'(clk_slow), 32'(e_slow));
    chk("model_div_cur", 32'(div_cur), 32'(e_div));
  end

  task automatic do_load(input logic [1:0] ch, input logic [DW-1:0] v);
    @(negedge CLK);
    div_load = 1'b1;
    div_ch = ch;
    div_value = v;
    @(negedge CLK);
    div_load = 1'b0;
  endtask

  task automatic wait_pulse(input int ch, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < 300) begin
      @(posedge CLK);
      #1;
      n++;
      if (clk_en[ch]) begin
        at = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL pulse_timeout ch%0d: got none expected a pulse within 300 edges", ch);
  endtask

  task automatic meas_release(input string name, output int r);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge CLK);
      #1;
      n++;
      if (!reset_out) break;
    end
    chk(name, 32'(n), 32'd18);
    r = cyc;
  endtask

  initial begin
    int r, a, b, c, d, w;
    logic prev;

    repeat (5) @(negedge CLK);
    chk("reset_hold_out", 32'(reset_out), 32'd1);
    chk("reset_hold_div", 32'(div_cur), 32'h0B0B0B);
    RESET = 1'b0;
    meas_release("release_latency", r);

    // default period on ch0
    wait_pulse(0, a);
    chk("first_pulse", 32'(a - r), 32'd12);
    chk("slow_after_1", 32'(clk_slow[0]), 32'd1);
    wait_pulse(0, b);
    chk("period_default", 32'(b - a), 32'd12);
    chk("slow_after_2", 32'(clk_slow[0]), 32'd0);
    chk("div_cur_default", 32'(div_cur[7:0]), 32'd11);

    // reload ch1 mid-period (counter at 5)
    wait_pulse(1, w);
    repeat (5) @(posedge CLK);
    do_load(2'd1, 8'd3);
    chk("div_cur_pending", 32'(div_cur[15:8]), 32'd11);
    wait_pulse(1, a);
    chk("reload_cur_period", 32'(a - w), 32'd12);
    chk("div_cur_reloaded", 32'(div_cur[15:8]), 32'd3);
    wait_pulse(1, b);
    chk("reload_period_1", 32'(b - a), 32'd4);
    wait_pulse(1, c);
    chk("reload_period_2", 32'(c - b), 32'd4);

    // D=0 on ch1
    do_load(2'd1, 8'd0);
    wait_pulse(1, d);
    chk("d0_switch", 32'(d - c), 32'd4);
    prev = clk_slow[1];
    for (int j = 0; j < 8; j++) begin
      @(posedge CLK);
      #1;
      chk("d0_en_high", 32'(clk_en[1]), 32'd1);
      chk("d0_slow_toggle", 32'(clk_slow[1] ^ prev), 32'd1);
      prev = clk_slow[1];
    end

    // load landing on ch2's wrap edge
    wait_pulse(2, w);
    repeat (11) @(posedge CLK);
    do_load(2'd2, 8'd5);
    wait_pulse(2, a);
    chk("wrap_load_next", 32'(a - w), 32'd18);

    // out-of-range channel is ignored
    do_load(2'd3, 8'd7);
    wait_pulse(2, a);
    wait_pulse(2, b);
    chk("bad_ch_period", 32'(b - a), 32'd6);
    chk("bad_ch_div_cur", 32'(div_cur), 32'h05000B);

    // maximum divider on ch0
    do_load(2'd0, 8'd255);
    wait_pulse(0, a);
    wait_pulse(0, b);
    chk("dmax_period", 32'(b - a), 32'd256);
    chk("dmax_div_cur", 32'(div_cur[7:0]), 32'd255);

    // reset mid-operation
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    chk("async_clk_en", 32'(clk_en), 32'd0);
    chk("async_clk_slow", 32'(clk_slow), 32'd0);
    chk("async_reset_out", 32'(reset_out), 32'd1);
    chk("async_div_cur", 32'(div_cur), 32'h0B0B0B);
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    meas_release("rerelease_latency", r);
    wait_pulse(0, a);
    chk("rerelease_first_pulse", 32'(a - r), 32'd12);
    wait_pulse(1, b);
    chk("rerelease_ch1_period", 32'(b - a), 32'd12);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
